// File: rtl/tse_csr_pkg.sv
// Shared definitions for the TSE MAC CSR subset: register map, command_config
// layout and the read-back view of command_config.
package tse_csr_pkg;

    localparam logic [7:0] ADDR_REV     = 8'h00;
    localparam logic [7:0] ADDR_SCRATCH = 8'h01;
    localparam logic [7:0] ADDR_CMD_CFG = 8'h02;
    localparam logic [7:0] ADDR_MAC0    = 8'h03;
    localparam logic [7:0] ADDR_MAC1    = 8'h04;
    localparam logic [7:0] ADDR_FRM_LEN = 8'h05;

    localparam int TX_ENA    = 0;
    localparam int RX_ENA    = 1;
    localparam int ETH_SPEED = 3;
    localparam int SW_RESET  = 13;

    typedef struct packed {
        logic [17:0] rsv_hi;     // [31:14] stored, no function
        logic        sw_reset;   // [13]
        logic [8:0]  rsv_mid;    // [12:4] stored, no function
        logic        eth_speed;  // [3]
        logic        rsv_2;      // [2] stored, no function
        logic        rx_ena;     // [1]
        logic        tx_ena;     // [0]
    } cmd_cfg_t;

    // While a soft reset is running the datapath enables are held off,
    // and software must see them as off too.
    function automatic logic [31:0] cmd_cfg_readback(input cmd_cfg_t cfg);
        cmd_cfg_t v;
        v = cfg;
        if (cfg.sw_reset) begin
            v.tx_ena = 1'b0;
            v.rx_ena = 1'b0;
        end
        return 32'(v);
    endfunction

endpackage

// File: rtl/avmm_wait_gen.sv
// Avalon-MM waitrequest generator: stalls each request for WAIT_STATES cycles,
// then accepts it on the edge where the request is seen with waitrequest low.
module avmm_wait_gen #(
    parameter int WAIT_STATES = 1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic req_i,
    output logic accept_o,
    output logic waitrequest_o
);

    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CW-1:0] CNT_TC = CW'(WAIT_STATES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Waitrequest is low only once the stall count has been served; with
    // WAIT_STATES = 0 the counter never leaves zero so the slave is zero-wait.
    assign waitrequest_o = (cnt_q != CNT_TC);
    assign accept_o      = req_i & ~waitrequest_o;

    // Count stalled cycles; idle, a dropped request or an acceptance restarts.
    always_comb begin
        cnt_d = cnt_q;
        if (!req_i || accept_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tse_csr_slave.sv
// TSE MAC CSR subset behind an Avalon-MM slave port. Holds command_config,
// MAC address, frame length, scratch and revision, runs the timed SW_RESET
// sequence and drives the MAC datapath enables.
module tse_csr_slave
    import tse_csr_pkg::*;
#(
    parameter int          WAIT_STATES     = 1,
    parameter int          RESET_CYCLES    = 16,
    parameter logic [31:0] REV_VALUE       = 32'h0000_0901,
    parameter int          FRM_LEN_DEFAULT = 1518
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [7:0]  address_i,
    input  logic        write_i,
    input  logic [31:0] writedata_i,
    input  logic        read_i,
    output logic [31:0] readdata_o,
    output logic        readdatavalid_o,
    output logic        waitrequest_o,
    output logic        tx_ena_o,
    output logic        rx_ena_o,
    output logic        eth_speed_o,
    output logic        sw_reset_busy_o,
    output logic [47:0] mac_addr_o,
    output logic [15:0] frm_length_o
);

    localparam logic [15:0] RST_LOAD = 16'(RESET_CYCLES);
    localparam logic [15:0] FRM_RST  = 16'(FRM_LEN_DEFAULT);

    logic        accept;
    logic        wr_acc;
    logic        rd_acc;
    logic        busy;
    logic [31:0] rd_mux;

    cmd_cfg_t    cfg_q,     cfg_d;
    logic [31:0] scratch_q, scratch_d;
    logic [31:0] mac0_q,    mac0_d;
    logic [15:0] mac1_q,    mac1_d;
    logic [15:0] frm_q,     frm_d;
    logic [15:0] rst_cnt_q, rst_cnt_d;
    logic [31:0] rdata_q,   rdata_d;
    logic        rvalid_q,  rvalid_d;

    avmm_wait_gen #(
        .WAIT_STATES (WAIT_STATES)
    ) u_wait_gen (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .req_i         (read_i | write_i),
        .accept_o      (accept),
        .waitrequest_o (waitrequest_o)
    );

    // A simultaneous read+write is treated as a write only.
    assign wr_acc = accept & write_i;
    assign rd_acc = accept & read_i & ~write_i;
    assign busy   = cfg_q.sw_reset;

    // Read data mux over the register map; unmapped words read as zero.
    always_comb begin
        rd_mux = '0;
        case (address_i)
            ADDR_REV:     rd_mux = REV_VALUE;
            ADDR_SCRATCH: rd_mux = scratch_q;
            ADDR_CMD_CFG: rd_mux = cmd_cfg_readback(cfg_q);
            ADDR_MAC0:    rd_mux = mac0_q;
            ADDR_MAC1:    rd_mux = {16'h0000, mac1_q};
            ADDR_FRM_LEN: rd_mux = {16'h0000, frm_q};
            default:      rd_mux = '0;
        endcase
    end

    // Next-state for registers, soft-reset timer and read response.
    always_comb begin
        cfg_d     = cfg_q;
        scratch_d = scratch_q;
        mac0_d    = mac0_q;
        mac1_d    = mac1_q;
        frm_d     = frm_q;
        rst_cnt_d = rst_cnt_q;
        rdata_d   = rdata_q;
        rvalid_d  = rd_acc;

        // Soft reset runs for RESET_CYCLES edges after the triggering write;
        // the terminal edge drops the enables and the busy bit, keeping the rest.
        if (busy) begin
            if (rst_cnt_q <= 16'd1) begin
                rst_cnt_d       = '0;
                cfg_d.tx_ena    = 1'b0;
                cfg_d.rx_ena    = 1'b0;
                cfg_d.sw_reset  = 1'b0;
            end else begin
                rst_cnt_d = rst_cnt_q - 16'd1;
            end
        end

        if (wr_acc) begin
            case (address_i)
                ADDR_SCRATCH: scratch_d = writedata_i;
                ADDR_CMD_CFG: begin
                    // Ignored while a soft reset is in progress, so the
                    // timer cannot be restarted or the enables re-armed.
                    if (!busy) begin
                        cfg_d = cmd_cfg_t'(writedata_i);
                        if (writedata_i[SW_RESET]) begin
                            rst_cnt_d = RST_LOAD;
                        end
                    end
                end
                ADDR_MAC0:    mac0_d = writedata_i;
                ADDR_MAC1:    mac1_d = writedata_i[15:0];
                ADDR_FRM_LEN: frm_d  = writedata_i[15:0];
                default:      ;
            endcase
        end

        if (rd_acc) begin
            rdata_d = rd_mux;
        end
    end

    // Register state; async reset also discards any pending read response.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cfg_q     <= '0;
            scratch_q <= '0;
            mac0_q    <= '0;
            mac1_q    <= '0;
            frm_q     <= FRM_RST;
            rst_cnt_q <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            cfg_q     <= cfg_d;
            scratch_q <= scratch_d;
            mac0_q    <= mac0_d;
            mac1_q    <= mac1_d;
            frm_q     <= frm_d;
            rst_cnt_q <= rst_cnt_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign readdata_o      = rdata_q;
    assign readdatavalid_o = rvalid_q;
    assign tx_ena_o        = cfg_q.tx_ena & ~busy;
    assign rx_ena_o        = cfg_q.rx_ena & ~busy;
    assign eth_speed_o     = cfg_q.eth_speed;
    assign sw_reset_busy_o = busy;
    assign mac_addr_o      = {mac1_q, mac0_q};
    assign frm_length_o    = frm_q;

endmodule

// File: tb/tb_tse_csr_slave.sv
// Bench for tse_csr_slave: instance 0 with one wait state, instance 1
// zero-wait. A register-level model predicts all outputs every cycle.
module tb_tse_csr_slave;

    localparam int RST_CYC = 16;

    logic        clk;
    logic        rst_n;
    logic        rd    [2];
    logic        wr    [2];
    logic [7:0]  addr  [2];
    logic [31:0] wdata [2];

    logic [31:0] rdata   [2];
    logic        rvalid  [2];
    logic        waitreq [2];
    logic        tx      [2];
    logic        rx      [2];
    logic        spd     [2];
    logic        busy    [2];
    logic [47:0] mac     [2];
    logic [15:0] frm     [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model state
    int          m_pend  [2];
    int          m_busy  [2];
    logic [31:0] m_scr   [2];
    logic [31:0] m_cfg   [2];
    logic [31:0] m_mac0  [2];
    logic [15:0] m_mac1  [2];
    logic [15:0] m_frm   [2];
    logic [31:0] m_rdata [2];
    logic        m_rvld  [2];

    tse_csr_slave #(
        .WAIT_STATES(1), .RESET_CYCLES(RST_CYC),
        .REV_VALUE(32'h0000_0901), .FRM_LEN_DEFAULT(1518)
    ) u_dut_ws1 (
        .clk_i(clk), .rst_n_i(rst_n), .address_i(addr[0]), .write_i(wr[0]),
        .writedata_i(wdata[0]), .read_i(rd[0]), .readdata_o(rdata[0]),
        .readdatavalid_o(rvalid[0]), .waitrequest_o(waitreq[0]),
        .tx_ena_o(tx[0]), .rx_ena_o(rx[0]), .eth_speed_o(spd[0]),
        .sw_reset_busy_o(busy[0]), .mac_addr_o(mac[0]), .frm_length_o(frm[0])
    );

    tse_csr_slave #(
        .WAIT_STATES(0), .RESET_CYCLES(RST_CYC),
        .REV_VALUE(32'h0000_0901), .FRM_LEN_DEFAULT(1518)
    ) u_dut_ws0 (
        .clk_i(clk), .rst_n_i(rst_n), .address_i(addr[1]), .write_i(wr[1]),
        .writedata_i(wdata[1]), .read_i(rd[1]), .readdata_o(rdata[1]),
        .readdatavalid_o(rvalid[1]), .waitrequest_o(waitreq[1]),
        .tx_ena_o(tx[1]), .rx_ena_o(rx[1]), .eth_speed_o(spd[1]),
        .sw_reset_busy_o(busy[1]), .mac_addr_o(mac[1]), .frm_length_o(frm[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    function automatic logic [31:0] m_read(input int k, input logic [7:0] a);
        case (a)
            8'h00:   return 32'h0000_0901;
            8'h01:   return m_scr[k];
            8'h02:   return (m_busy[k] > 0) ? (m_cfg[k] & ~32'h3) : m_cfg[k];
            8'h03:   return m_mac0[k];
            8'h04:   return {16'h0, m_mac1[k]};
            8'h05:   return {16'h0, m_frm[k]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Behavioural model: a request is taken once it has waited WAIT_STATES
    // cycles; soft reset lasts RST_CYC edges from the triggering write.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_pend[k] = 0;  m_busy[k] = 0;  m_scr[k] = 0;  m_cfg[k] = 0;
                m_mac0[k] = 0;  m_mac1[k] = 0;  m_frm[k] = 16'd1518;
                m_rdata[k] = 0; m_rvld[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                logic        req, acc, was_busy;
                logic [31:0] rv;
                req      = rd[k] | wr[k];
                acc      = req && (m_pend[k] >= ws_of(k));
                rv       = m_read(k, addr[k]);
                was_busy = (m_busy[k] > 0);
                if (m_busy[k] > 0) begin
                    m_busy[k] = m_busy[k] - 1;
                    if (m_busy[k] == 0) m_cfg[k] = m_cfg[k] & ~32'h0000_2003;
                end
                m_rvld[k] = 1'b0;
                if (acc && wr[k]) begin
                    case (addr[k])
                        8'h01: m_scr[k] = wdata[k];
                        8'h02: if (!was_busy) begin
                                   m_cfg[k] = wdata[k];
                                   if (wdata[k][13]) m_busy[k] = RST_CYC;
                               end
                        8'h03: m_mac0[k] = wdata[k];
                        8'h04: m_mac1[k] = wdata[k][15:0];
                        8'h05: m_frm[k]  = wdata[k][15:0];
                        default: ;
                    endcase
                end else if (acc && rd[k]) begin
                    m_rvld[k]  = 1'b1;
                    m_rdata[k] = rv;
                end
                m_pend[k] = (!req || acc) ? 0 : m_pend[k] + 1;
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                logic mb;
                mb = (m_busy[k] > 0);
                chk("readdata",    64'(rdata[k]),   64'(m_rdata[k]));
                chk("rvalid",      64'(rvalid[k]),  64'(m_rvld[k]));
                chk("waitrequest", 64'(waitreq[k]), 64'(m_pend[k] < ws_of(k)));
                chk("tx_ena",      64'(tx[k]),      64'(m_cfg[k][0] & ~mb));
                chk("rx_ena",      64'(rx[k]),      64'(m_cfg[k][1] & ~mb));
                chk("eth_speed",   64'(spd[k]),     64'(m_cfg[k][3]));
                chk("sw_busy",     64'(busy[k]),    64'(mb));
                chk("mac_addr",    64'(mac[k]),     64'({m_mac1[k], m_mac0[k]}));
                chk("frm_length",  64'(frm[k]),     64'(m_frm[k]));
            end
        end
    end

    task automatic access(input int k, input logic r, input logic w,
                          input logic [7:0] a, input logic [31:0] d,
                          output logic [31:0] rdat, output logic rv,
                          output int stalls, output int ac);
        int n;
        n = 0;
        stalls = 0;
        @(posedge clk); #2;
        rd[k] = r; wr[k] = w; addr[k] = a; wdata[k] = d;
        @(negedge clk);
        while (waitreq[k] && n < 20) begin
            stalls++; n++;
            @(negedge clk);
        end
        if (n >= 20) chk("handshake_timeout", 64'(n), 64'(0));
        @(posedge clk); #2;
        ac = cyc;
        rd[k] = 1'b0; wr[k] = 1'b0;
        @(negedge clk);
        rv   = rvalid[k];
        rdat = rdata[k];
    endtask

    initial begin
        logic [31:0] d, rdv;
        logic        v;
        int          st, ac, wr_ac, n;
        logic [31:0] got [3];
        logic        gv  [3];
        logic [7:0]  ra  [3];

        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [31:0] rdv, d;
        logic        v;
        int          st, ac, wr_ac, n, op;
        logic [7:0]  a;
        logic [31:0] got [3];
        logic        gv  [3];
        logic [7:0]  ra  [3];

        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rd[k] = 0; wr[k] = 0; addr[k] = 0; wdata[k] = 0;
        end
        #12;
        chk("rst_readdata",  64'(rdata[0]),   64'(0));
        chk("rst_rvalid",    64'(rvalid[0]),  64'(0));
        chk("rst_wait_ws1",  64'(waitreq[0]), 64'(1));
        chk("rst_wait_ws0",  64'(waitreq[1]), 64'(0));
        chk("rst_frm",       64'(frm[0]),     64'(1518));
        chk("rst_mac",       64'(mac[1]),     64'(0));
        #10 rst_n = 1'b1;

        // one-wait-state instance: revision and frame length read-back
        access(0, 1, 0, 8'h00, 0, rdv, v, st, ac);
        chk("rev_stalls", 64'(st), 64'(1));
        chk("rev_valid",  64'(v),  64'(1));
        chk("rev_data",   64'(rdv), 64'h0000_0901);
        access(0, 1, 0, 8'h05, 0, rdv, v, st, ac);
        chk("frm_stalls", 64'(st), 64'(1));
        chk("frm_data",   64'(rdv), 64'h0000_05EE);

        // soft reset, an ignored write during it, and its duration
        access(0, 0, 1, 8'h02, 32'h0000_2008, rdv, v, st, wr_ac);
        access(0, 1, 0, 8'h02, 0, rdv, v, st, ac);
        chk("swr_read_busy", 64'(rdv), 64'h0000_2008);
        chk("swr_busy_flag", 64'(busy[0]), 64'(1));
        access(0, 0, 1, 8'h02, 32'h0000_0003, rdv, v, st, ac);
        chk("swr_write_ignored_tx", 64'(tx[0]), 64'(0));
        access(0, 1, 0, 8'h02, 0, rdv, v, st, ac);
        chk("swr_cfg_unchanged", 64'(rdv), 64'h0000_2008);
        n = 0;
        while (busy[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("swr_length", 64'(cyc - wr_ac), 64'(RST_CYC));
        access(0, 1, 0, 8'h02, 0, rdv, v, st, ac);
        chk("swr_done_read", 64'(rdv), 64'h0000_0008);
        chk("swr_done_busy", 64'(busy[0]), 64'(0));
        access(0, 0, 1, 8'h02, 32'h0000_000B, rdv, v, st, ac);
        chk("en_tx",  64'(tx[0]),  64'(1));
        chk("en_rx",  64'(rx[0]),  64'(1));
        chk("en_spd", 64'(spd[0]), 64'(1));
        access(0, 1, 0, 8'h02, 0, rdv, v, st, ac);
        chk("en_read", 64'(rdv), 64'h0000_000B);

        // zero-wait instance: back-to-back reads
        access(1, 0, 1, 8'h01, 32'hA5A5_5A5A, rdv, v, st, ac);
        access(1, 0, 1, 8'h03, 32'h1122_3344, rdv, v, st, ac);
        access(1, 0, 1, 8'h04, 32'hFFFF_5566, rdv, v, st, ac);
        chk("mac_addr_lit", 64'(mac[1]), 64'h5566_1122_3344);
        ra[0] = 8'h01; ra[1] = 8'h03; ra[2] = 8'h04;
        @(posedge clk); #2;
        rd[1] = 1'b1; addr[1] = ra[0];
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            if (i < 2) addr[1] = ra[i+1];
            else       rd[1] = 1'b0;
            @(negedge clk);
            gv[i]  = rvalid[1];
            got[i] = rdata[1];
        end
        chk("b2b_v0", 64'(gv[0]), 64'(1));
        chk("b2b_v1", 64'(gv[1]), 64'(1));
        chk("b2b_v2", 64'(gv[2]), 64'(1));
        chk("b2b_d0", 64'(got[0]), 64'hA5A5_5A5A);
        chk("b2b_d1", 64'(got[1]), 64'h1122_3344);
        chk("b2b_d2", 64'(got[2]), 64'h0000_5566);
        @(negedge clk);
        chk("hold_valid", 64'(rvalid[1]), 64'(0));
        chk("hold_data",  64'(rdata[1]),  64'h0000_5566);

        access(1, 1, 0, 8'h7F, 0, rdv, v, st, ac);
        chk("unmapped_valid", 64'(v), 64'(1));
        chk("unmapped_data",  64'(rdv), 64'(0));
        access(1, 1, 1, 8'h01, 32'hDEAD_BEEF, rdv, v, st, ac);
        chk("rdwr_no_valid", 64'(v), 64'(0));
        access(1, 1, 0, 8'h01, 0, rdv, v, st, ac);
        chk("rdwr_scratch", 64'(rdv), 64'hDEAD_BEEF);

        // randomized traffic on both instances, including abandoned stalls
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 150; i++) begin
                n = int'($urandom_range(0, 7));
                a = (n < 6) ? 8'(n) : 8'($urandom_range(6, 255));
                d = $urandom;
                if (a == 8'h02) d[13] = ($urandom_range(0, 2) == 0);
                op = int'($urandom_range(0, 9));
                if (op == 9) begin
                    @(posedge clk); #2;
                    rd[k] = 1'b1; addr[k] = a;
                    @(posedge clk); #2;
                    rd[k] = 1'b0;
                end else begin
                    access(k, (op <= 3) || (op == 8), (op >= 4), a, d, rdv, v, st, ac);
                end
                repeat ($urandom_range(0, 2)) @(posedge clk);
            end
        end

        // async reset while soft reset busy and a read is stalled
        repeat (RST_CYC + 4) @(posedge clk);
        access(0, 0, 1, 8'h02, 32'h0000_2003, rdv, v, st, ac);
        access(0, 0, 1, 8'h01, 32'h1234_5678, rdv, v, st, ac);
        @(posedge clk); #2;
        rd[0] = 1'b1; addr[0] = 8'h01;
        @(negedge clk);
        chk("pre_rst_stalled", 64'(waitreq[0]), 64'(1));
        chk("pre_rst_busy",    64'(busy[0]),    64'(1));
        #1 rst_n = 1'b0;
        #1;
        rd[0] = 1'b0;
        chk("mid_rst_busy",   64'(busy[0]),    64'(0));
        chk("mid_rst_rvalid", 64'(rvalid[0]),  64'(0));
        chk("mid_rst_rdata",  64'(rdata[0]),   64'(0));
        chk("mid_rst_wait",   64'(waitreq[0]), 64'(1));
        chk("mid_rst_tx",     64'(tx[0]),      64'(0));
        chk("mid_rst_frm",    64'(frm[0]),     64'(1518));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_valid", 64'(rvalid[0]), 64'(0));
        end
        access(0, 1, 0, 8'h01, 0, rdv, v, st, ac);
        chk("post_rst_scratch", 64'(rdv), 64'(0));

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
